// File: rtl/seg7_digit_reader_if.sv
// seg7_digit_reader_if
//   Groups the digit-beat input stream and the result output stream of
//   seg7_digit_reader.
//   master : producer/consumer side (drives SEG_*, VALUE_READY)
//   slave  : reader side (drives SEG_READY, VALUE, VALUE_VALID, DIGIT_COUNT,
//            ERR and, with SEG7_READER_DP_EN, DP_SEEN/DP_POS)
//   Config macro: SEG7_READER_DP_EN widens SEG_IN to 8 bits (bit7 = DP,
//   active-low) and adds DP_SEEN/DP_POS.
interface seg7_digit_reader_if;
`ifdef SEG7_READER_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  logic [SEG_W-1:0] SEG_IN;
  logic             SEG_VALID;
  logic             SEG_LAST;
  logic             SEG_READY;
  logic [13:0]      VALUE;
  logic             VALUE_VALID;
  logic             VALUE_READY;
  logic [2:0]       DIGIT_COUNT;
  logic             ERR;
`ifdef SEG7_READER_DP_EN
  logic             DP_SEEN;
  logic [2:0]       DP_POS;
`endif

  modport master (
    output SEG_IN, SEG_VALID, SEG_LAST, VALUE_READY,
`ifdef SEG7_READER_DP_EN
    input  DP_SEEN, DP_POS,
`endif
    input  SEG_READY, VALUE, VALUE_VALID, DIGIT_COUNT, ERR
  );

  modport slave (
    input  SEG_IN, SEG_VALID, SEG_LAST, VALUE_READY,
`ifdef SEG7_READER_DP_EN
    output DP_SEEN, DP_POS,
`endif
    output SEG_READY, VALUE, VALUE_VALID, DIGIT_COUNT, ERR
  );
endinterface

// File: rtl/seg7_digit_reader.sv
// seg7_digit_reader
//   Decodes a stream of active-low 7-segment patterns (one digit per beat,
//   SEG_LAST marks the final digit) into a binary value of up to MAX_DIGITS
//   decimal digits. Leading blanks are skipped; malformed numbers are
//   reported with ERR=1 and VALUE=0.
//   Ports:
//     CLOCK_50 : clock, rising edge
//     RESET    : asynchronous, active-high
//     bus      : seg7_digit_reader_if.slave (beat input / result output)
//   Config macro: SEG7_READER_DP_EN enables decimal-point tracking
//   (DP_SEEN, DP_POS).
module seg7_digit_reader #(
  parameter int MAX_DIGITS = 4
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  seg7_digit_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t      r_state;
  logic [13:0] r_acc;
  logic [13:0] r_value;
  logic [2:0]  r_count;
  logic        r_err;
  logic        r_value_valid;
  logic        r_seg_ready;
`ifdef SEG7_READER_DP_EN
  logic        r_dp_seen;
  logic [2:0]  r_dp_pos;
  logic        w_dp;
`endif

  logic [6:0]  w_seg;
  logic        w_is_digit;
  logic        w_is_blank;
  logic [3:0]  w_digit;
  logic        w_accept;
  logic        w_beat_err;
  logic        w_stay_idle;
  logic [13:0] w_acc_nxt;
  logic [2:0]  w_cnt_nxt;

  assign w_seg    = bus.SEG_IN[6:0];
  assign w_accept = bus.SEG_VALID & r_seg_ready;
`ifdef SEG7_READER_DP_EN
  assign w_dp     = ~bus.SEG_IN[7];
`endif

  always_comb begin
    w_is_digit = 1'b1;
    w_is_blank = 1'b0;
    w_digit    = 4'd0;
    case (w_seg)
      7'h40: w_digit = 4'd0;
      7'h79: w_digit = 4'd1;
      7'h24: w_digit = 4'd2;
      7'h30: w_digit = 4'd3;
      7'h19: w_digit = 4'd4;
      7'h12: w_digit = 4'd5;
      7'h02: w_digit = 4'd6;
      7'h78: w_digit = 4'd7;
      7'h00: w_digit = 4'd8;
      7'h10: w_digit = 4'd9;
      7'h7F: begin
        w_is_digit = 1'b0;
        w_is_blank = 1'b1;
      end
      default: w_is_digit = 1'b0;
    endcase
  end

  // Classify the current beat against the state it would be accepted in.
  always_comb begin
    w_beat_err  = 1'b0;
    w_stay_idle = 1'b0;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_is_digit) begin
          w_acc_nxt = {10'd0, w_digit};
          w_cnt_nxt = 3'd1;
        end else if (w_is_blank) begin
          w_stay_idle = 1'b1;
        end else begin
          w_beat_err = 1'b1;
        end
      end
      S_ACCUM: begin
        if (!w_is_digit || r_count >= 3'(MAX_DIGITS)) begin
          w_beat_err = 1'b1;
        end else begin
          // acc <= 999 here, so the result stays within 9999
          w_acc_nxt = r_acc * 14'd10 + {10'd0, w_digit};
          w_cnt_nxt = r_count + 3'd1;
        end
      end
      default: ;
    endcase
`ifdef SEG7_READER_DP_EN
    if (w_dp && (r_state == S_IDLE || r_state == S_ACCUM) &&
        (!w_is_digit || r_dp_seen))
      w_beat_err = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_value       <= '0;
      r_count       <= '0;
      r_err         <= 1'b0;
      r_value_valid <= 1'b0;
      r_seg_ready   <= 1'b1;
`ifdef SEG7_READER_DP_EN
      r_dp_seen     <= 1'b0;
      r_dp_pos      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            if (w_beat_err) begin
              // count keeps the digits accepted before the error
              r_err <= 1'b1;
              if (bus.SEG_LAST) begin
                r_state       <= S_OUT;
                r_value       <= '0;
                r_value_valid <= 1'b1;
                r_seg_ready   <= 1'b0;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_acc   <= w_acc_nxt;
              r_count <= w_cnt_nxt;
`ifdef SEG7_READER_DP_EN
              if (w_dp) begin
                r_dp_seen <= 1'b1;
                r_dp_pos  <= w_cnt_nxt;
              end
`endif
              if (bus.SEG_LAST) begin
                r_state       <= S_OUT;
                r_value       <= w_acc_nxt;
                r_value_valid <= 1'b1;
                r_seg_ready   <= 1'b0;
              end else if (!w_stay_idle) begin
                r_state <= S_ACCUM;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_accept && bus.SEG_LAST) begin
            r_state       <= S_OUT;
            r_value       <= '0;
            r_value_valid <= 1'b1;
            r_seg_ready   <= 1'b0;
          end
        end
        S_OUT: begin
          if (bus.VALUE_READY) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_value       <= '0;
            r_count       <= '0;
            r_err         <= 1'b0;
            r_value_valid <= 1'b0;
            r_seg_ready   <= 1'b1;
`ifdef SEG7_READER_DP_EN
            r_dp_seen     <= 1'b0;
            r_dp_pos      <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.SEG_READY   = r_seg_ready;
  assign bus.VALUE       = r_value;
  assign bus.VALUE_VALID = r_value_valid;
  assign bus.DIGIT_COUNT = r_count;
  assign bus.ERR         = r_err;
`ifdef SEG7_READER_DP_EN
  assign bus.DP_SEEN     = r_dp_seen;
  assign bus.DP_POS      = r_dp_pos;
`endif

endmodule

// File: tb/tb_seg7_digit_reader.sv
// tb_seg7_digit_reader
//   Directed bench for seg7_digit_reader with hand-computed expectations.
//   Honours SEG7_READER_DP_EN when the design is built with it.
module tb_seg7_digit_reader;
`ifdef SEG7_READER_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  logic CLOCK_50;
  logic RESET;
  int   n_pass;
  int   n_fail;
  int   n_total;

  seg7_digit_reader_if bus ();

  seg7_digit_reader #(.MAX_DIGITS(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One accepted beat; returns #1 after the accepting edge.
  task automatic beat(input logic [6:0] code, input logic last, input logic dp);
    logic [7:0] full;
    full = {~dp, code};
    bus.SEG_IN    = full[SW-1:0];
    bus.SEG_VALID = 1'b1;
    bus.SEG_LAST  = last;
    @(posedge CLOCK_50);
    #1;
    bus.SEG_VALID = 1'b0;
    bus.SEG_LAST  = 1'b0;
  endtask

  task automatic result(input string tag, input int v, input int c, input int e);
    chk({tag, ".valid"}, 32'(bus.VALUE_VALID), 1);
    chk({tag, ".value"}, 32'(bus.VALUE), 32'(v));
    chk({tag, ".count"}, 32'(bus.DIGIT_COUNT), 32'(c));
    chk({tag, ".err"},   32'(bus.ERR), 32'(e));
    chk({tag, ".ready"}, 32'(bus.SEG_READY), 0);
  endtask

  task automatic consume(input string tag);
    bus.VALUE_READY = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.VALUE_READY = 1'b0;
    chk({tag, ".idle_valid"}, 32'(bus.VALUE_VALID), 0);
    chk({tag, ".idle_ready"}, 32'(bus.SEG_READY), 1);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    RESET = 1'b1;
    bus.SEG_IN = '1; bus.SEG_VALID = 1'b0; bus.SEG_LAST = 1'b0; bus.VALUE_READY = 1'b0;
    #1;
    chk("rst.value", 32'(bus.VALUE), 0);
    chk("rst.valid", 32'(bus.VALUE_VALID), 0);
    chk("rst.err",   32'(bus.ERR), 0);
    chk("rst.count", 32'(bus.DIGIT_COUNT), 0);
    chk("rst.ready", 32'(bus.SEG_READY), 1);
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;

    // leading blank, 1, 5 -> 15
    beat(7'h7F, 1'b0, 1'b0);
    beat(7'h79, 1'b0, 1'b0);
    chk("n15.pre_valid", 32'(bus.VALUE_VALID), 0);
    beat(7'h12, 1'b1, 1'b0);
    result("n15", 15, 2, 0);
    consume("n15");

    // 9999 at full width
    for (int i = 0; i < 3; i++) beat(7'h10, 1'b0, 1'b0);
    beat(7'h10, 1'b1, 1'b0);
    result("n9999", 9999, 4, 0);
    consume("n9999");

    // fifth digit overflows the digit budget
    for (int i = 0; i < 4; i++) beat(7'h10, 1'b0, 1'b0);
    beat(7'h10, 1'b1, 1'b0);
    result("ovf", 0, 4, 1);
    consume("ovf");

    // undefined pattern mid-number -> drain until LAST
    beat(7'h24, 1'b0, 1'b0);
    beat(7'h55, 1'b0, 1'b0);
    chk("drain.ready", 32'(bus.SEG_READY), 1);
    chk("drain.valid", 32'(bus.VALUE_VALID), 0);
    beat(7'h30, 1'b1, 1'b0);
    result("drain", 0, 1, 1);
    consume("drain");

    // 42 held while consumer stalls; offered beats must be ignored
    beat(7'h19, 1'b0, 1'b0);
    beat(7'h24, 1'b1, 1'b0);
    bus.SEG_IN = 7'h79; bus.SEG_VALID = 1'b1; bus.SEG_LAST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK_50); #1;
      result("hold42", 42, 2, 0);
    end
    bus.SEG_VALID = 1'b0; bus.SEG_LAST = 1'b0;
    consume("hold42");
    beat(7'h79, 1'b1, 1'b0);
    result("after42", 1, 1, 0);
    consume("after42");

    // VALUE_READY outside OUT is ignored
    bus.VALUE_READY = 1'b1;
    beat(7'h02, 1'b0, 1'b0);
    bus.VALUE_READY = 1'b0;
    beat(7'h78, 1'b1, 1'b0);
    result("n67", 67, 2, 0);
    consume("n67");

    // all-blank number
    beat(7'h7F, 1'b0, 1'b0);
    beat(7'h7F, 1'b1, 1'b0);
    result("blank", 0, 0, 0);
    consume("blank");

    // blank inside a number, error carried on the LAST beat
    beat(7'h79, 1'b0, 1'b0);
    beat(7'h7F, 1'b1, 1'b0);
    result("midblank", 0, 1, 1);
    consume("midblank");

    // undefined single-beat number
    beat(7'h55, 1'b1, 1'b0);
    result("undef1", 0, 0, 1);
    consume("undef1");

    // asynchronous reset mid-number
    beat(7'h24, 1'b0, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst.count", 32'(bus.DIGIT_COUNT), 0);
    chk("arst.valid", 32'(bus.VALUE_VALID), 0);
    chk("arst.ready", 32'(bus.SEG_READY), 1);
    RESET = 1'b0;
    @(posedge CLOCK_50); #1;
    beat(7'h19, 1'b1, 1'b0);
    result("arst4", 4, 1, 0);

    // reset while a result is pending discards it
    #2;
    RESET = 1'b1;
    #1;
    chk("rout.valid", 32'(bus.VALUE_VALID), 0);
    chk("rout.value", 32'(bus.VALUE), 0);
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge CLOCK_50);
    #1;
    chk("rout.stay_valid", 32'(bus.VALUE_VALID), 0);
    chk("rout.stay_ready", 32'(bus.SEG_READY), 1);

`ifdef SEG7_READER_DP_EN
    beat(7'h79, 1'b0, 1'b0);
    beat(7'h24, 1'b0, 1'b1);
    beat(7'h30, 1'b1, 1'b0);
    result("dp123", 123, 3, 0);
    chk("dp123.seen", 32'(bus.DP_SEEN), 1);
    chk("dp123.pos",  32'(bus.DP_POS), 2);
    consume("dp123");
    chk("dpclr.seen", 32'(bus.DP_SEEN), 0);
    beat(7'h79, 1'b0, 1'b1);
    beat(7'h24, 1'b1, 1'b1);
    result("dp2nd", 0, 1, 1);
    consume("dp2nd");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
